resp_misr_collector: RTL

- Downstream stage of a generated fuzz DUT. Consumes the DUT's 1-bit output `y` one sample per clock.
- Skips a programmable warm-up, then compresses a fixed-length window of samples into a MISR signature. Also counts ones in the window.
- Presents the result with a valid/ack handshake and compares it against an expected signature. The cross-tool harness uses this to detect simulator/synthesis divergence without dumping waveforms.

---
 rtl/fuzz_harness_pkg.sv | 17 +
 rtl/misr_step.sv | 19 +
 rtl/resp_misr_collector.sv | 118 +++++++++++
 3 files changed

// File: rtl/fuzz_harness_pkg.sv
// Shared types and defaults for the fuzz-harness response path.
// Used by the MISR collector and the stimulus-side LFSR.
package fuzz_harness_pkg;

  localparam int          SIG_W_DEF = 16;
  localparam int          LEN_W_DEF = 8;
  localparam logic [15:0] POLY_DEF  = 16'hB400;
  localparam logic [15:0] SEED_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/misr_step.sv
// One Galois MISR/LFSR step: shift right, fold feedback by POLY,
// then inject the serial input bit at the MSB.
module misr_step
  import fuzz_harness_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic             y_i,
  output logic [SIG_W-1:0] nxt_o
);

  always_comb begin
    nxt_o = (sig_i >> 1) ^ (sig_i[0] ? POLY : '0);
    nxt_o[SIG_W-1] = nxt_o[SIG_W-1] ^ y_i;
  end

endmodule

// File: rtl/resp_misr_collector.sv
// Skips a warm-up, compresses a window of DUT samples into a MISR
// signature plus ones-count, and hands it out via valid/ack.
module resp_misr_collector
  import fuzz_harness_pkg::*;
#(
  parameter int               SIG_W  = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF),
  parameter int               LEN_W  = LEN_W_DEF,
  parameter int               WARMUP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] win_len,
  input  logic             y_in,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             busy,
  output logic [SIG_W-1:0] sig,
  output logic [LEN_W-1:0] ones,
  output logic             sig_valid,
  input  logic             sig_ack,
  output logic             sig_match
);

  // Last warm-up count; only meaningful when WARMUP > 0.
  localparam logic [LEN_W-1:0] WU_LAST = LEN_W'(WARMUP - 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [LEN_W-1:0] ones_q, ones_d;
  logic [SIG_W-1:0] sig_nxt;

  misr_step #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .sig_i (sig_q),
    .y_i   (y_in),
    .nxt_o (sig_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sig_q   <= SEED;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sig_q   <= sig_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sig_d   = sig_q;
    ones_d  = ones_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = win_len;
          sig_d  = SEED;
          ones_d = '0;
          cnt_d  = '0;
          if (WARMUP > 0)
            state_d = S_WARMUP;
          else if (win_len != '0)
            state_d = S_CAPTURE;
          else
            state_d = S_DONE;
        end
      end
      S_WARMUP: begin
        if (cnt_q == WU_LAST) begin
          cnt_d   = '0;
          state_d = (len_q == '0) ? S_DONE : S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        sig_d  = sig_nxt;
        ones_d = ones_q + LEN_W'(y_in);
        // len_q is nonzero here, so len_q-1 cannot wrap.
        if (cnt_q == len_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (sig_ack)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    sig_valid = (state_q == S_DONE);
    sig_match = sig_valid && (sig_q == exp_sig);
  end

  assign sig  = sig_q;
  assign ones = ones_q;

endmodule
